// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver:
// frame geometry and the serial FSM state encoding.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 8;

  // Counter widths derived from the frame geometry.
  localparam int SPACING_W = $clog2(OVERSAMPLE);
  localparam int BIT_CNT_W = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small single-clock byte FIFO feeding the UART transmitter.
// The head entry is presented combinationally so the FSM can load it into
// the shift register on the same tick that pops it.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  // Guard both ends so a stray request can never corrupt the occupancy.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign full     = (count_reg == CNT_FULL);
  assign empty    = (count_reg == '0);
  assign pop_data = mem[rd_ptr_reg];

  // Storage array: no reset so it maps onto plain RAM/LUT storage.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (pop_ok && !push_ok) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, paced by an 8x-baud tick shared with the receiver.
// Bytes queue in uart_tx_fifo; the FSM serialises them back-to-back.
module uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud8_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy
);

  localparam logic [SPACING_W-1:0] SPACING_LAST = SPACING_W'(OVERSAMPLE - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST     = BIT_CNT_W'(DATA_BITS - 1);

  uart_state_t          state_reg,   state_next;
  logic [SPACING_W-1:0] spacing_reg, spacing_next;
  logic [BIT_CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg,   shift_next;
  logic                 tx_reg,      tx_next;

  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_data;

  uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (tx_valid && tx_ready),
    .push_data(tx_data),
    .pop      (fifo_pop),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // tx_ready comes only from the registered FIFO count, never from tx_valid.
  assign tx_ready = !fifo_full;
  assign tx_busy  = !fifo_empty || (state_reg != IDLE);
  assign tx       = tx_reg;

  // Next-state, counters, shift register and line level; all frozen between ticks.
  always_comb begin
    state_next   = state_reg;
    spacing_next = spacing_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    fifo_pop     = 1'b0;

    if (baud8_tick) begin
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            state_next   = START;
            fifo_pop     = 1'b1;
            shift_next   = fifo_data;
            spacing_next = '0;
            bit_cnt_next = '0;
          end
        end
        START: begin
          spacing_next = spacing_reg + SPACING_W'(1);
          if (spacing_reg == SPACING_LAST) begin
            state_next = DATA;
          end
        end
        DATA: begin
          spacing_next = spacing_reg + SPACING_W'(1);
          if (spacing_reg == SPACING_LAST) begin
            shift_next   = shift_reg >> 1;
            bit_cnt_next = bit_cnt_reg + BIT_CNT_W'(1);
            if (bit_cnt_reg == BIT_LAST) begin
              state_next = STOP;
            end
          end
        end
        STOP: begin
          spacing_next = spacing_reg + SPACING_W'(1);
          if (spacing_reg == SPACING_LAST) begin
            if (!fifo_empty) begin
              // Chain straight into the next frame with no idle gap.
              state_next   = START;
              fifo_pop     = 1'b1;
              shift_next   = fifo_data;
              spacing_next = '0;
              bit_cnt_next = '0;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // Line level follows the state being entered, so it flips on the same edge.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame and idles the line.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      spacing_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      spacing_reg <= spacing_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
    end
  end

endmodule
